// File: rtl/clkdiv_pkg.sv
// Shared constants for the clock-enable generator: default divisor width,
// 100 MHz rate divisors and the per-channel action encoding.
package clkdiv_pkg;

   localparam int CNT_W = 20;

   localparam logic [CNT_W-1:0] DIV_PIX_100M   = 20'd4;
   localparam logic [CNT_W-1:0] DIV_SEG_100M   = 20'd262144;
   localparam logic [CNT_W-1:0] DIV_LOGIC_100M = 20'd1000000;

   // Channel 0 in the LSBs.
   localparam logic [3*CNT_W-1:0] DIV_RESET = {DIV_LOGIC_100M, DIV_SEG_100M, DIV_PIX_100M};

   // What a channel does on the coming edge (clr is handled separately).
   typedef enum logic [1:0] {
      ACT_COUNT = 2'd0,
      ACT_WRAP  = 2'd1,
      ACT_IDLE  = 2'd2,
      ACT_SYNC  = 2'd3
   } ch_act_e;

endpackage

// File: rtl/clk_en_channel.sv
// One clock-enable channel: counter, active/pending divisor and registered
// tick / square-wave / pending outputs. New divisors only take effect on a wrap.
module clk_en_channel
   import clkdiv_pkg::*;
#(
   parameter int               CNT_W    = 20,
   parameter logic [CNT_W-1:0] DIV_INIT = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   output logic             tick,
   output logic             sq,
   output logic             pend
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_act;
   logic [CNT_W-1:0] div_pend;
   logic [CNT_W-1:0] next_div;
   logic             apply;
   ch_act_e          act;

   always_comb begin
      act = ACT_COUNT;
      if (sync)
         act = ACT_SYNC;
      else if (div_act == '0)
         act = ACT_IDLE;
      else if (cnt == div_act - CNT_W'(1))
         act = ACT_WRAP;
   end

   // A write landing on a wrap/sync edge bypasses the pending register.
   assign next_div = wr ? wr_div : div_pend;
   assign apply    = wr | pend;

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt      <= '0;
         div_act  <= DIV_INIT;
         div_pend <= DIV_INIT;
         pend     <= 1'b0;
         tick     <= 1'b0;
         sq       <= 1'b0;
      end else begin
         if (wr)
            div_pend <= wr_div;
         case (act)
            ACT_SYNC: begin
               cnt  <= '0;
               tick <= 1'b0;
               sq   <= 1'b0;
               pend <= 1'b0;
               if (apply)
                  div_act <= next_div;
            end
            ACT_WRAP: begin
               cnt  <= '0;
               tick <= 1'b1;
               sq   <= ~sq;
               pend <= 1'b0;
               if (apply)
                  div_act <= next_div;
            end
            ACT_IDLE: begin
               // Disabled: a previously pending divisor goes live now, a
               // write in this cycle becomes pending for the next edge.
               cnt  <= '0;
               tick <= 1'b0;
               pend <= wr;
               if (pend)
                  div_act <= div_pend;
            end
            default: begin
               cnt  <= cnt + CNT_W'(1);
               tick <= 1'b0;
               if (wr)
                  pend <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: decodes divisor writes, fans out sync
// and instantiates one clk_en_channel per output.
module clk_enable_gen
   import clkdiv_pkg::*;
#(
   parameter int                      NUM_CH    = 3,
   parameter int                      CNT_W     = 20,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_RESET = clkdiv_pkg::DIV_RESET,
   localparam int                     CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              sync,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq,
   output logic [NUM_CH-1:0] pend
);

   logic [NUM_CH-1:0] wr_sel;

   // Out-of-range channel numbers select nothing.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (wr_en && (32'(wr_ch) == i))
            wr_sel[i] = 1'b1;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_en_channel #(
         .CNT_W    (CNT_W),
         .DIV_INIT (DIV_RESET[g*CNT_W +: CNT_W])
      ) u_ch (
         .clk    (clk),
         .clr    (clr),
         .sync   (sync),
         .wr     (wr_sel[g]),
         .wr_div (wr_div),
         .tick   (tick[g]),
         .sq     (sq[g]),
         .pend   (pend[g])
      );
   end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: reset defaults, reload, disable, divide-by-1,
// bad address, sync with write and mid-operation reset.
module tb_clk_enable_gen;

   logic       clk = 1'b0;
   logic       clr, sync, wr_en;
   logic [1:0] wr_ch;
   logic [19:0] wr_div;
   logic [2:0] tick, sq, pend;

   int n_chk = 0;
   int n_bad = 0;

   clk_enable_gen dut (
      .clk    (clk),
      .clr    (clr),
      .sync   (sync),
      .wr_en  (wr_en),
      .wr_ch  (wr_ch),
      .wr_div (wr_div),
      .tick   (tick),
      .sq     (sq),
      .pend   (pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n rising edges; inputs change and outputs are sampled 1 ns after.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] ch, input logic [19:0] d);
      wr_en  = 1'b1;
      wr_ch  = ch;
      wr_div = d;
   endtask

   initial begin
      clr = 1'b1; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
      step(2);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_sq",   32'(sq),   0);
      chk("rst_pend", 32'(pend), 0);
      clr = 1'b0;

      // defaults: ch0 div 4, others far too slow to tick here
      for (int e = 1; e <= 100; e++) begin
         step(1);
         chk("def_tick0", 32'(tick[0]), 32'(e % 4 == 0));
         chk("def_sq0",   32'(sq[0]),   32'((e / 4) % 2));
         chk("def_tick12", 32'(tick[2:1]), 0);
      end

      // reload mid-period: write 6 when cnt=1
      step(1);
      wr(0, 20'd6);
      step(1);
      wr_en = 1'b0;
      chk("rl_pend_set", 32'(pend[0]), 1);
      chk("rl_tick_a",   32'(tick[0]), 0);
      step(1);
      chk("rl_tick_b",   32'(tick[0]), 0);
      step(1);
      chk("rl_old_tick", 32'(tick[0]), 1);
      chk("rl_pend_clr", 32'(pend[0]), 0);
      chk("rl_sq_a",     32'(sq[0]),   0);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         chk("rl_new_tick", 32'(tick[0]), 32'(k == 6));
      end
      chk("rl_sq_b", 32'(sq[0]), 1);

      // disable: div 0 takes effect on the coming wrap
      wr(0, 20'd0);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         wr_en = 1'b0;
         chk("dis_tick", 32'(tick[0]), 32'(k == 6));
      end
      chk("dis_pend", 32'(pend[0]), 0);
      chk("dis_sq",   32'(sq[0]),   0);
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk("dis_quiet", 32'(tick[0]), 0);
         chk("dis_sqhold", 32'(sq[0]), 0);
      end

      // re-enable with div 2
      wr(0, 20'd2);
      step(1);
      wr_en = 1'b0;
      chk("en_pend", 32'(pend[0]), 1);
      step(1);
      chk("en_apply_pend", 32'(pend[0]), 0);
      chk("en_apply_tick", 32'(tick[0]), 0);
      step(1);
      chk("en_t1", 32'(tick[0]), 0);
      step(1);
      chk("en_t2", 32'(tick[0]), 1);
      chk("en_sq2", 32'(sq[0]), 1);
      step(1);
      chk("en_t3", 32'(tick[0]), 0);
      step(1);
      chk("en_t4", 32'(tick[0]), 1);
      chk("en_sq4", 32'(sq[0]), 0);

      // divide by 1
      wr(0, 20'd1);
      step(1);
      wr_en = 1'b0;
      chk("d1_pend", 32'(pend[0]), 1);
      chk("d1_t0",   32'(tick[0]), 0);
      step(1);
      chk("d1_apply", 32'(tick[0]), 1);
      chk("d1_sq0",   32'(sq[0]),   1);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         chk("d1_tick", 32'(tick[0]), 1);
         chk("d1_sq",   32'(sq[0]),   32'(k % 2 == 0));
      end

      // bad address: nothing changes
      wr(2'd3, 20'd7);
      step(1);
      wr_en = 1'b0;
      chk("bad_pend", 32'(pend), 0);
      chk("bad_tick", 32'(tick), 3'b001);
      for (int k = 1; k <= 4; k++) begin
         step(1);
         chk("bad_keep", 32'(tick), 3'b001);
         chk("bad_pend2", 32'(pend), 0);
      end

      // back to div 4: write lands on a wrap, so no pending phase
      wr(0, 20'd4);
      step(1);
      wr_en = 1'b0;
      chk("r4_pend", 32'(pend[0]), 0);
      chk("r4_tick", 32'(tick[0]), 1);

      // sync with simultaneous write to ch2
      sync = 1'b1;
      wr(2, 20'd5);
      step(1);
      sync = 1'b0; wr_en = 1'b0;
      chk("sy_tick", 32'(tick), 0);
      chk("sy_sq",   32'(sq),   0);
      chk("sy_pend", 32'(pend), 0);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         chk("sy_tick0", 32'(tick[0]), 32'(k == 4));
         chk("sy_tick1", 32'(tick[1]), 0);
         chk("sy_tick2", 32'(tick[2]), 32'(k == 5));
      end
      chk("sy_sq02", 32'(sq), 3'b101);

      // reset mid-operation with a pending write
      wr(0, 20'd9);
      step(1);
      wr_en = 1'b0;
      chk("mr_pend", 32'(pend[0]), 1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("mr_tick", 32'(tick), 0);
      chk("mr_sq",   32'(sq),   0);
      chk("mr_pend0", 32'(pend), 0);
      for (int e = 1; e <= 8; e++) begin
         step(1);
         chk("mr_def0", 32'(tick[0]), 32'(e % 4 == 0));
         chk("mr_def2", 32'(tick[2]), 0);
         chk("mr_pend", 32'(pend), 0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Programmable multi-channel clock-enable generator for the VGA/display subsystem: from the single master clock it produces per-channel one-cycle enable ticks and 50 % square waves with runtime-reloadable divisors. It replaces fixed single-divider logic. Pixel, seven-segment refresh and game-logic rate enables all come from one instance, so downstream logic stays on `clk` with no derived clocks.

## Interface
- `NUM_CH`, 3: number of independent channels.
- `CNT_W`, 20: divisor/counter width in bits.
- `DIV_RESET`, {20'd1000000, 20'd262144, 20'd4}: packed `NUM_CH*CNT_W` reset divisors, channel 0 in the LSBs. With a 100 MHz clock these give 25 MHz pixel, 381.47 Hz segment and 100 Hz logic rates.
- `clk`  in  1: master clock, 100 MHz.
- `clr`  in  1: reset, synchronous, active-high.
- `sync`  in  1: restart all channels in phase.
- `wr_en`  in  1: divisor write strobe.
- `wr_ch`  in  `$clog2(NUM_CH)` (min 1): target channel.
- `wr_div`  in  `CNT_W`: new divisor. 0 disables the channel.
- `tick`  out  `NUM_CH`: one-cycle enable pulse per channel, registered.
- `sq`  out  `NUM_CH`: square wave per channel, period 2×div, registered.
- `pend`  out  `NUM_CH`: write accepted but not yet applied.

## Operation
- Per channel, these registers exist: `cnt[CNT_W]`, `div_act`, `div_pend`, `pend`, `tick`, `sq`.
- Reset (`clr`=1 at a rising edge): `cnt`=0, `div_act`=`DIV_RESET` slice, `pend`=0, `tick`=0, `sq`=0. This overrides every other input, including mid-operation writes and `sync`.
- Counting (`div_act`≠0):
  - If `cnt`==`div_act`−1: `cnt`←0, `tick`←1, `sq`←~`sq`.
  - Otherwise: `cnt`←`cnt`+1, `tick`←0.
- Disabled (`div_act`=0): `cnt` holds 0, `tick`=0, `sq` holds its value.
- `div_act`=1: `tick` is constantly 1 and `sq` toggles every cycle.
- Write: when `wr_en`=1 and `wr_ch`<`NUM_CH`, `div_pend[wr_ch]`←`wr_div` and `pend`←1.
  - `wr_ch`≥`NUM_CH`: ignored, no state change.
  - Back-to-back writes to one channel: the last one wins.
- Glitch-free apply:
  - The pending divisor loads into `div_act` only on the wrap cycle (the same edge that asserts `tick`). `cnt`←0 and `pend`←0 on that edge.
  - If `div_act`=0, the pending divisor applies on the next edge.
  - A wrap cycle therefore always completes the old period. No shortened or stretched pulse is ever produced.
- `sync`=1: every channel takes `cnt`←0, `tick`←0, `sq`←0, and applies any pending divisor immediately (`pend`←0).
- `wr_en` and `sync` in the same cycle: the write data is applied directly by the sync.
- Write and wrap on the targeted channel in the same cycle: the new value is applied on that wrap.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- After `clr` deasserts, with div=N, `tick` is first high after the N-th rising edge, then every N edges.
- `sq` first rises together with the first `tick`, giving a duty of exactly N/2N.
- Write latency:
  - `pend` is high one edge after `wr_en`.
  - The new period begins at the next wrap, at most `div_act` cycles later.
- After `sync`, the first tick of every channel arrives `div` edges after the sync edge, so all channels are phase-aligned.
- Counter arithmetic is unsigned `CNT_W`-bit. The compare is against `div_act`−1, so the counter never overflows.

## Structure
- Shared package `clkdiv_pkg`: `CNT_W` default, constants `DIV_PIX_100M`=4, `DIV_SEG_100M`=262144, `DIV_LOGIC_100M`=1000000, and the packed default `DIV_RESET`.
- Sub-module `clk_en_channel`: one counter, the active/pending divisor registers, and tick/sq/pend logic.
- Top: write-address decode, `sync` fan-out, and a generate loop of `NUM_CH` channels.

## Test plan
- Reset defaults, 100 cycles after `clr`: `tick[0]` high on edges 4, 8, 12…; `sq[0]` period 8 at 50 %. `tick[1]`/`tick[2]` stay low.
- Reload mid-period: ch0 div=4, write div=6 at `cnt`=1 → `pend[0]`=1 next edge. The old tick still lands at `cnt`=3, then ticks follow every 6 edges and `pend[0]` clears on that wrap.
- Disable/enable: write div=0 → `tick` stops after the current wrap and `sq` holds. Write div=2 → `tick` resumes 2 edges after apply.
- Divide-by-1 and bad address: div=1 → `tick`=1 continuously and `sq` toggles each cycle. Write with `wr_ch`=3 (`NUM_CH`=3) → no register changes.
- Sync with simultaneous write: `sync`+`wr_en`(ch2, div=5) → all `cnt`=0 and `sq`=0. Ch2 ticks 5 edges later; ch0 ticks 4 edges later.
- Reset mid-operation: assert `clr` with a pending write and `sq`=1 → every output is 0, `pend`=0, and defaults are restored on the next edge.
